store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: queues processor stores that hit the MMIO window and drains
// them in order over a valid/ready peripheral bus.
module store_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            ALUResult,
  input  logic [31:0]            WriteData,
  output logic                   Stall,
  output logic                   bus_valid,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_data,
  input  logic                   bus_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_data;

  logic          w_hit;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_next_head;
  logic [CW-1:0] w_next_count;
  logic [31:0]   w_next_addr;
  logic [31:0]   w_next_data;

  // Handshake decode and next-state computation.
  always_comb begin
    w_hit       = (ALUResult[31:12] == MMIO_BASE[31:12]);
    w_full      = (r_count == FULL_CNT);
    w_push      = MemWrite & w_hit & ~w_full;
    w_pop       = (r_count != {CW{1'b0}}) & bus_ready;
    w_next_head = w_pop ? (r_head + AW'(1)) : r_head;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + CW'(1);
      2'b01:   w_next_count = r_count - CW'(1);
      default: w_next_count = r_count;
    endcase
    // The presented entry is registered; it may be the one written on this same edge.
    if (w_next_count == {CW{1'b0}}) begin
      w_next_addr = r_bus_addr;
      w_next_data = r_bus_data;
    end else if (w_push && (r_tail == w_next_head)) begin
      w_next_addr = ALUResult;
      w_next_data = WriteData;
    end else begin
      w_next_addr = r_mem_addr[w_next_head];
      w_next_data = r_mem_data[w_next_head];
    end
  end

  // Entry storage; contents are meaningless while not occupied, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= ALUResult;
      r_mem_data[r_tail] <= WriteData;
    end
  end

  // Pointers, occupancy and presented head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= {AW{1'b0}};
      r_tail     <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_bus_addr <= 32'h0000_0000;
      r_bus_data <= 32'h0000_0000;
    end else begin
      r_head     <= w_next_head;
      r_tail     <= w_push ? (r_tail + AW'(1)) : r_tail;
      r_count    <= w_next_count;
      r_bus_addr <= w_next_addr;
      r_bus_data <= w_next_data;
    end
  end

  assign Stall     = MemWrite & w_hit & w_full;
  assign bus_valid = (r_count != {CW{1'b0}});
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign bus_addr  = r_bus_addr;
  assign bus_data  = r_bus_data;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a vector table plus directed
// sequences, all checked against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [19:0] WIN = 20'h00001;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        Stall;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_ready;
  logic [2:0]  count;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH), .MMIO_BASE(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .Stall(Stall), .bus_valid(bus_valid),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_ready(bus_ready),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        e_stall;
    logic [2:0]  e_count;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t        tbl [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q [$];
  logic [31:0] obs [$];
  logic [31:0] m_last_addr;
  logic [31:0] m_last_data;
  logic        s_stall, s_valid, s_empty;
  logic [2:0]  s_count;
  logic [31:0] s_addr, s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, sample at negedge, check against model, advance model.
  task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic rst, output logic accepted);
    logic hit;
    logic do_pop;
    MemWrite = mw; ALUResult = a; WriteData = d; bus_ready = rdy; reset = rst;
    @(negedge clk);
    s_stall = Stall; s_count = count; s_valid = bus_valid; s_empty = empty;
    s_addr = bus_addr; s_data = bus_data;
    hit = (a[31:12] == WIN);
    chk("stall", {31'd0, s_stall}, {31'd0, (mw && hit && (q.size() == DEPTH))});
    chk("count", {29'd0, s_count}, q.size());
    chk("valid", {31'd0, s_valid}, {31'd0, (q.size() != 0)});
    chk("empty", {31'd0, s_empty}, {31'd0, (q.size() == 0)});
    chk("bus_addr", s_addr, (q.size() != 0) ? q[0][63:32] : m_last_addr);
    chk("bus_data", s_data, (q.size() != 0) ? q[0][31:0] : m_last_data);
    accepted = 1'b0;
    if (rst) begin
      q.delete();
      m_last_addr = 32'h0;
      m_last_data = 32'h0;
    end else begin
      do_pop   = rdy && (q.size() != 0);
      accepted = mw && hit && (q.size() < DEPTH);
      if (do_pop) begin
        obs.push_back(s_data);
        void'(q.pop_front());
      end
      if (accepted) q.push_back({a, d});
      if (q.size() != 0) begin
        m_last_addr = q[0][63:32];
        m_last_data = q[0][31:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   i;
    int   cyc;

    // Single store, held outputs, out-of-window store, fill/stall/drain.
    tbl[0]  = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 32'h0000_0040, 32'h55, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 32'h0000_1004, 32'd1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 32'h0000_1008, 32'd2, 1'b0, 1'b0, 3'd1, 1'b1, 32'h0000_1004, 32'd1};
    tbl[7]  = '{1'b1, 32'h0000_100C, 32'd3, 1'b0, 1'b0, 3'd2, 1'b1, 32'h0000_1004, 32'd1};
    tbl[8]  = '{1'b1, 32'h0000_1010, 32'd4, 1'b0, 1'b0, 3'd3, 1'b1, 32'h0000_1004, 32'd1};
    tbl[9]  = '{1'b1, 32'h0000_1014, 32'd5, 1'b0, 1'b1, 3'd4, 1'b1, 32'h0000_1004, 32'd1};
    tbl[10] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h0000_1004, 32'd1};
    tbl[11] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd4, 1'b1, 32'h0000_1004, 32'd1};
    tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd3, 1'b1, 32'h0000_1008, 32'd2};
    tbl[13] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h0000_100C, 32'd3};
    tbl[14] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_1010, 32'd4};
    tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_1010, 32'd4};

    reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; bus_ready = 1'b0;
    q.delete(); obs.delete();
    m_last_addr = 32'h0; m_last_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].mw, tbl[k].addr, tbl[k].data, tbl[k].ready, 1'b0, acc);
      chk($sformatf("v%0d_stall", k), {31'd0, s_stall}, {31'd0, tbl[k].e_stall});
      chk($sformatf("v%0d_count", k), {29'd0, s_count}, {29'd0, tbl[k].e_count});
      chk($sformatf("v%0d_valid", k), {31'd0, s_valid}, {31'd0, tbl[k].e_valid});
      chk($sformatf("v%0d_addr", k), s_addr, tbl[k].e_addr);
      chk($sformatf("v%0d_data", k), s_data, tbl[k].e_data);
    end

    // Simultaneous push and pop with two entries buffered.
    obs.delete();
    cycle(1'b1, 32'h0000_1020, 32'hA1, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_1024, 32'hA2, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_1028, 32'hA3, 1'b1, 1'b0, acc);
    chk("pp_count_before", {29'd0, s_count}, 32'd2);
    chk("pp_head_before", s_data, 32'hA1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("pp_count_after", {29'd0, s_count}, 32'd2);
    chk("pp_head_after", s_data, 32'hA2);
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      cyc++;
    end
    chk("pp_n", obs.size(), 32'd3);
    if (obs.size() == 3) begin
      chk("pp_o0", obs[0], 32'hA1);
      chk("pp_o1", obs[1], 32'hA2);
      chk("pp_o2", obs[2], 32'hA3);
    end

    // Wrap-around: ten stores, ready toggling, processor holds while stalled.
    obs.delete();
    i = 0; cyc = 0;
    while (i < 10 && cyc < 60) begin
      cycle(1'b1, 32'h0000_1000 + 32'(i * 4), 32'(10 + i), cyc[0], 1'b0, acc);
      if (acc) i++;
      cyc++;
    end
    while (q.size() != 0 && cyc < 100) begin
      cycle(1'b0, 32'h0, 32'h0, cyc[0], 1'b0, acc);
      cyc++;
    end
    chk("wrap_pushed", i, 32'd10);
    chk("wrap_n", obs.size(), 32'd10);
    for (int k = 0; k < obs.size() && k < 10; k++)
      chk($sformatf("wrap_o%0d", k), obs[k], 32'(10 + k));

    // Reset in the middle of a stalled handshake, also racing a push.
    cycle(1'b1, 32'h0000_1030, 32'hC1, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_1034, 32'hC2, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_1038, 32'hC3, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_103C, 32'hC4, 1'b0, 1'b1, acc);
    chk("rst_count_before", {29'd0, s_count}, 32'd3);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("rst_count", {29'd0, s_count}, 32'd0);
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_data", s_data, 32'h0);
    chk("rst_stall", {31'd0, s_stall}, 32'd0);
    obs.delete();
    cycle(1'b1, 32'h0000_1044, 32'h77, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("post_rst_count", {29'd0, s_count}, 32'd1);
    chk("post_rst_addr", s_addr, 32'h0000_1044);
    chk("post_rst_data", s_data, 32'h77);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("post_rst_empty", {31'd0, s_empty}, 32'd1);
    chk("post_rst_n", obs.size(), 32'd1);
    if (obs.size() == 1) chk("post_rst_o0", obs[0], 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
